macc_stim_gen: RTL and testbench
================================

# macc_stim_gen

Synthesizable operand generator that drives a pair of `unsig_altmult_accum` MACC instances, the exact and the approximate one, in place of file-based stimulus. It produces pseudo-random 8-bit operand streams with `clken`/`sload` sequencing in fixed-length accumulation windows. It also emits a strobe marking the cycle on which the MACC outputs hold a completed window, which lets a downstream error monitor sample both results.

## Interface
- `WIDTH`, 8: operand width; must be ≤ 16.
- `SEED_A`, 16'hACE1: LFSR seed for `dataa`; 0 is replaced by 16'hACE1.
- `SEED_B`, 16'h1D2C: LFSR seed for `datab`; 0 is replaced by 16'hACE1.
- `WINDOW`, 16: accumulations per window, ≥ 2.
- `NUM_WINDOWS`, 4: windows per run, ≥ 1.
- `LAT`, 2: MACC latency in enabled cycles from operand to accumulated output, ≥ 1.

Ports:
- `Clk` in 1: clock. One clock domain; all logic on the rising edge.
- `aclr_n` in 1: asynchronous, active-low reset.
- `start` in 1: starts a run; sampled in IDLE or DONE.
- `pause` in 1: freezes the run while high.
- `dataa` out WIDTH: operand A to both MACCs.
- `datab` out WIDTH: operand B to both MACCs.
- `clken` out 1: MACC clock enable.
- `sload` out 1: MACC accumulator load, high on beat 0 of each window.
- `result_valid` out 1: one-cycle strobe; MACC outputs hold the full sum of window `result_idx`.
- `result_idx` out 8: index of the completed window.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. All outputs are registered.
- LFSRs: two 16-bit Galois LFSRs, next = (l >> 1) ^ (l[0] ? 16'hB400 : 0). Operands are `l[WIDTH-1:0]`, presented before stepping.
- IDLE: `clken`=0, `sload`=0, data=0. When `start`=1, reload both LFSRs from their seeds, clear the beat and window counters, and go to RUN.
- RUN, with `pause`=0, on each cycle:
  - `clken`=1; `dataa`/`datab` take the LFSR values.
  - Both LFSRs step; the beat counter increments.
  - `sload`=1 only when beat = 0.
- RUN, window boundary:
  - When beat = WINDOW-1, the beat counter wraps to 0 and the window counter increments.
  - After the last beat of window NUM_WINDOWS-1, go to DRAIN.
- RUN, with `pause`=1: `clken`=0 and `sload`=0. Data, counters and LFSRs hold their values.
- DRAIN: `clken`=1, data=0, `sload`=0 for exactly LAT cycles. `pause` is ignored. Then go to DONE.
- DONE: `done`=1, `clken`=0. When `start`=1, reseed and go to RUN. DONE is held until `start`.
- `start` is ignored in RUN and DRAIN.
- Completion tracking uses a LAT-deep delay line of {last-beat flag, window index}.
  - It shifts only on cycles where the registered `clken`=1.
  - Its head drives `result_valid` and `result_idx`.
  - This keeps the strobe aligned with the MACC pipeline even when `pause` is used.
- Reset (`aclr_n`=0, at any time, including mid-run):
  - All outputs go to 0 and the state goes to IDLE.
  - LFSRs load their seeds; counters and the delay line clear.
  - The run is not resumed after reset.

## Timing
- `start` sampled at edge k: the first operand, with `sload`=1, is on the outputs after edge k+1.
- An uninterrupted run lasts WINDOW·NUM_WINDOWS RUN cycles, then LAT DRAIN cycles, then DONE.
- `result_valid` for window w appears LAT enabled cycles after that window's last operand cycle.
  - For windows before the last, this falls inside the next window's RUN cycles.
  - For the final window, it falls on the last DRAIN cycle.
- `busy` falls and `done` rises on the same edge.
- `pause` asserted at edge k: `clken`=0 from the output cycle after edge k+1. On deassertion, the stream continues with the next unconsumed LFSR value; no operand is lost or repeated.
- Simultaneous events:
  - `start` and `pause` together in IDLE: enter RUN and pause immediately, with no operand emitted.
  - `start` in DONE restarts with identical sequences.

## Test plan
- Reset and start with default parameters:
  - First `dataa` = 8'hE1, second `dataa` = 8'h70.
  - `sload` is high only on output cycles 0, 16, 32 and 48.
  - `clken` is high for 66 consecutive cycles.
  - `done` rises after cycle 66.
- Result strobes:
  - `result_valid` pulses 4 times, with `result_idx` = 0, 1, 2, 3.
  - A golden model fed the same operands matches both MACC outputs exactly at each strobe.
- Pause 5 cycles in the middle of window 1:
  - `clken` is low for 5 cycles; the operand sequence is unchanged.
  - The strobe for window 1 is delayed by exactly 5 cycles.
- Assert `aclr_n`=0 mid-window 2:
  - All outputs are 0 while reset is low.
  - A subsequent `start` replays from 8'hE1.
- Pulse `start` during RUN: no effect. Pulse `start` in DONE: the run repeats with a bit-identical stream.
- Stress configuration: `WINDOW`=2, `NUM_WINDOWS`=1, `LAT`=1.
  - 2 RUN cycles, 1 DRAIN cycle.
  - A single strobe with `result_idx`=0 on the DRAIN cycle.

Source files
------------

// File: rtl/macc_stim_gen.sv
// Pseudo-random operand generator for a pair of MACC instances. It sequences clken/sload
// in fixed-length accumulation windows and strobes when a completed window sum is visible.
module macc_stim_gen #(
  parameter int          WIDTH       = 8,
  parameter logic [15:0] SEED_A      = 16'hACE1,
  parameter logic [15:0] SEED_B      = 16'h1D2C,
  parameter int          WINDOW      = 16,
  parameter int          NUM_WINDOWS = 4,
  parameter int          LAT         = 2
) (
  input  logic             Clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] dataa,
  output logic [WIDTH-1:0] datab,
  output logic             clken,
  output logic             sload,
  output logic             result_valid,
  output logic [7:0]       result_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] SA = (SEED_A == 16'h0) ? 16'hACE1 : SEED_A;
  localparam logic [15:0] SB = (SEED_B == 16'h0) ? 16'hACE1 : SEED_B;
  localparam int BW = $clog2(WINDOW);
  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_state;
  logic [15:0]      r_lfsr_a, r_lfsr_b, w_lfsr_a, w_lfsr_b;
  logic [BW-1:0]    r_beat, w_beat;
  logic [7:0]       r_win, w_win;
  logic [DW-1:0]    r_dcnt, w_dcnt;
  logic [WIDTH-1:0] r_dataa, r_datab, w_dataa, w_datab;
  logic             r_clken, r_sload, r_busy, r_done;
  logic             w_clken, w_sload, w_busy, w_done;
  logic             r_tag_last, w_tag_last;
  logic [7:0]       r_tag_idx, w_tag_idx;
  logic             r_rv;
  logic [7:0]       r_ridx;
  logic [8:0]       w_tag, w_head;

  function automatic logic [15:0] f_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always_comb begin
    w_state    = r_state;
    w_lfsr_a   = r_lfsr_a;
    w_lfsr_b   = r_lfsr_b;
    w_beat     = r_beat;
    w_win      = r_win;
    w_dcnt     = r_dcnt;
    w_dataa    = r_dataa;
    w_datab    = r_datab;
    w_clken    = 1'b0;
    w_sload    = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_tag_last = 1'b0;
    w_tag_idx  = r_win;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_dataa = '0;
        w_datab = '0;
        w_done  = (r_state == S_DONE);
        if (start) begin
          w_state  = S_RUN;
          w_lfsr_a = SA;
          w_lfsr_b = SB;
          w_beat   = '0;
          w_win    = '0;
          w_busy   = 1'b1;
          w_done   = 1'b0;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        // a paused cycle holds data, counters and LFSRs; only clken/sload drop
        if (!pause) begin
          w_clken    = 1'b1;
          w_dataa    = r_lfsr_a[WIDTH-1:0];
          w_datab    = r_lfsr_b[WIDTH-1:0];
          w_sload    = (r_beat == '0);
          w_lfsr_a   = f_step(r_lfsr_a);
          w_lfsr_b   = f_step(r_lfsr_b);
          w_tag_last = (r_beat == BW'(WINDOW - 1));
          if (r_beat == BW'(WINDOW - 1)) begin
            w_beat = '0;
            w_win  = r_win + 8'd1;
            if (r_win == 8'(NUM_WINDOWS - 1)) begin
              w_state = S_DRAIN;
              w_dcnt  = '0;
            end
          end else begin
            w_beat = r_beat + BW'(1);
          end
        end
      end
      S_DRAIN: begin
        w_dataa = '0;
        w_datab = '0;
        if (r_dcnt == DW'(LAT)) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_clken = 1'b1;
          w_busy  = 1'b1;
          w_dcnt  = r_dcnt + DW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state    <= S_IDLE;
      r_lfsr_a   <= SA;
      r_lfsr_b   <= SB;
      r_beat     <= '0;
      r_win      <= '0;
      r_dcnt     <= '0;
      r_dataa    <= '0;
      r_datab    <= '0;
      r_clken    <= 1'b0;
      r_sload    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tag_last <= 1'b0;
      r_tag_idx  <= '0;
    end else begin
      r_state    <= w_state;
      r_lfsr_a   <= w_lfsr_a;
      r_lfsr_b   <= w_lfsr_b;
      r_beat     <= w_beat;
      r_win      <= w_win;
      r_dcnt     <= w_dcnt;
      r_dataa    <= w_dataa;
      r_datab    <= w_datab;
      r_clken    <= w_clken;
      r_sload    <= w_sload;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_tag_last <= w_tag_last;
      r_tag_idx  <= w_tag_idx;
    end
  end

  // Completion tracking: the tag of the operand on the outputs is stage 0; each enabled
  // cycle moves it one stage, so the head register fires after LAT enabled MACC edges.
  assign w_tag = {r_tag_last, r_tag_idx};

  if (LAT == 1) begin : g_nodl
    assign w_head = w_tag;
  end else begin : g_dl
    logic [LAT-2:0][8:0] r_dl;
    always_ff @(posedge Clk or negedge aclr_n) begin
      if (!aclr_n) begin
        r_dl <= '0;
      end else if (r_clken) begin
        r_dl[0] <= w_tag;
        for (int k = 1; k <= LAT - 2; k++) r_dl[k] <= r_dl[k-1];
      end
    end
    assign w_head = r_dl[LAT-2];
  end

  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_rv   <= 1'b0;
      r_ridx <= '0;
    end else begin
      r_rv <= r_clken & w_head[8];
      if (r_clken && w_head[8]) r_ridx <= w_head[7:0];
    end
  end

  assign dataa        = r_dataa;
  assign datab        = r_datab;
  assign clken        = r_clken;
  assign sload        = r_sload;
  assign result_valid = r_rv;
  assign result_idx   = r_ridx;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_macc_stim_gen.sv
// Directed bench for macc_stim_gen: default instance plus a WINDOW=2/NUM_WINDOWS=1/LAT=1
// instance, with a behavioural two-stage MACC to confirm strobe alignment with the sums.
module tb_macc_stim_gen;

  logic       Clk = 1'b0;
  logic       aclr_n, start, pause;
  logic [7:0] dataa, datab, result_idx;
  logic       clken, sload, result_valid, busy, done;

  logic       s_start;
  logic [7:0] s_dataa, s_datab, s_idx;
  logic       s_clken, s_sload, s_rv, s_busy, s_done;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 Clk = ~Clk;

  macc_stim_gen u_dut (
    .Clk(Clk), .aclr_n(aclr_n), .start(start), .pause(pause),
    .dataa(dataa), .datab(datab), .clken(clken), .sload(sload),
    .result_valid(result_valid), .result_idx(result_idx), .busy(busy), .done(done)
  );

  macc_stim_gen #(.WINDOW(2), .NUM_WINDOWS(1), .LAT(1)) u_stress (
    .Clk(Clk), .aclr_n(aclr_n), .start(s_start), .pause(1'b0),
    .dataa(s_dataa), .datab(s_datab), .clken(s_clken), .sload(s_sload),
    .result_valid(s_rv), .result_idx(s_idx), .busy(s_busy), .done(s_done)
  );

  // Two enabled stages: operand register, then accumulator (sload restarts the sum).
  logic [7:0]  m_a = '0, m_b = '0;
  logic        m_s = 1'b0;
  logic [31:0] m_acc = '0;
  always @(posedge Clk) begin
    if (clken) begin
      m_a   <= dataa;
      m_b   <= datab;
      m_s   <= sload;
      m_acc <= m_s ? 32'(m_a) * 32'(m_b) : m_acc + 32'(m_a) * 32'(m_b);
    end
  end

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One full run from IDLE/DONE. pa/plen: pause window in output cycles; sa: start pulse
  // cycle during RUN; t0..t3: expected strobe cycles (cycle 0 = first operand).
  task automatic run_check(input int pa, input int plen, input int sa,
                           input int t0, input int t1, input int t2, input int t3);
    logic [15:0] la, lb;
    logic [7:0]  ea, eb, ha, hb;
    logic        eclk, esl, ebusy, edone, fin;
    int          n, d, nclk, nsl, nstb;
    int          tst[4];
    logic [31:0] sums[4];
    tst  = '{t0, t1, t2, t3};
    sums = '{default: 32'd0};
    la = 16'hACE1; lb = 16'h1D2C;
    n = 0; d = 0; nclk = 0; nsl = 0; nstb = 0; ha = '0; hb = '0; fin = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ack", {busy, done, clken}, 3'b100);
    for (int c = 0; c < 200 && !fin; c++) begin
      pause = (c >= pa && c < pa + plen);
      start = (c == sa);
      step();
      eclk = 1'b0; esl = 1'b0; ebusy = 1'b1; edone = 1'b0;
      if (pause) begin
        ea = ha; eb = hb;
      end else if (n < 64) begin
        ea = la[7:0]; eb = lb[7:0]; eclk = 1'b1; esl = (n % 16 == 0);
        sums[n/16] = sums[n/16] + 32'(ea) * 32'(eb);
        la = lfsr_nx(la); lb = lfsr_nx(lb);
        n++;
      end else if (d < 2) begin
        ea = '0; eb = '0; eclk = 1'b1;
        d++;
      end else begin
        ea = '0; eb = '0; ebusy = 1'b0; edone = 1'b1; fin = 1'b1;
      end
      ha = ea; hb = eb;
      chk($sformatf("cyc%0d", c), {dataa, datab, clken, sload, busy, done},
          {ea, eb, eclk, esl, ebusy, edone});
      if (n == 1 && eclk) chk("first_dataa", dataa, 8'hE1);
      if (n == 2 && eclk) chk("second_dataa", dataa, 8'h70);
      nclk += int'(clken);
      nsl  += int'(sload);
      if (result_valid) begin
        if (nstb < 4) begin
          chk($sformatf("strobe%0d_idx", nstb), result_idx, nstb);
          chk($sformatf("strobe%0d_sum", nstb), m_acc, sums[nstb]);
          chk($sformatf("strobe%0d_cyc", nstb), c, tst[nstb]);
        end
        nstb++;
      end
    end
    pause = 1'b0;
    start = 1'b0;
    chk("reached_done", fin, 1);
    chk("clken_cycles", nclk, 66);
    chk("sload_count", nsl, 4);
    chk("strobe_count", nstb, 4);
  endtask

  initial begin
    aclr_n = 1'b0; start = 1'b0; pause = 1'b0; s_start = 1'b0;
    step(); step();
    chk("reset_outs", {dataa, datab, clken, sload, result_valid, result_idx, busy, done}, 29'h0);
    chk("reset_stress", {s_dataa, s_datab, s_clken, s_sload, s_rv, s_idx, s_busy, s_done}, 29'h0);
    aclr_n = 1'b1;
    step(); step();
    chk("idle_no_start", {clken, busy, done, dataa}, 11'h0);

    // plain run, then hold in DONE
    run_check(1000, 0, -1, 17, 33, 49, 65);
    step(); step();
    chk("done_held", {done, busy, clken}, 3'b100);

    // start from DONE with a 5-cycle pause inside window 1
    run_check(20, 5, -1, 17, 38, 54, 70);

    // start pulse while running is ignored
    run_check(1000, 0, 30, 17, 33, 49, 65);

    // reset in the middle of window 2
    start = 1'b1; step(); start = 1'b0;
    repeat (41) step();
    chk("pre_reset_run", {busy, clken}, 2'b11);
    aclr_n = 1'b0;
    #1;
    chk("midrun_reset", {dataa, datab, clken, sload, result_valid, result_idx, busy, done}, 29'h0);
    step();
    chk("reset_clocked", {dataa, datab, clken, sload, result_valid, result_idx, busy, done}, 29'h0);
    aclr_n = 1'b1;
    step(); step();
    chk("no_resume", {busy, done, clken}, 3'b000);
    run_check(1000, 0, -1, 17, 33, 49, 65);

    // start together with pause from IDLE
    aclr_n = 1'b0; #1; aclr_n = 1'b1;
    step();
    start = 1'b1; pause = 1'b1;
    step();
    start = 1'b0;
    chk("sp_enter", {busy, clken, sload, dataa}, {3'b100, 8'h00});
    step(); step();
    chk("sp_hold", {busy, clken, sload, dataa}, {3'b100, 8'h00});
    pause = 1'b0;
    step();
    chk("sp_first", {clken, sload, dataa}, {2'b11, 8'hE1});
    aclr_n = 1'b0; #1; aclr_n = 1'b1;

    // stress instance: 2 operands, 1 drain cycle, strobe on drain
    step();
    s_start = 1'b1; step(); s_start = 1'b0;
    chk("st_ack", {s_busy, s_clken, s_done}, 3'b100);
    step();
    chk("st_c0", {s_dataa, s_datab, s_clken, s_sload, s_busy, s_done, s_rv}, {8'hE1, 8'h2C, 5'b11100});
    step();
    chk("st_c1", {s_dataa, s_datab, s_clken, s_sload, s_busy, s_done, s_rv}, {8'h70, 8'h96, 5'b10100});
    step();
    chk("st_drain", {s_dataa, s_datab, s_clken, s_sload, s_busy, s_done, s_rv}, {8'h00, 8'h00, 5'b10101});
    chk("st_idx", s_idx, 8'h00);
    step();
    chk("st_done", {s_dataa, s_datab, s_clken, s_sload, s_busy, s_done, s_rv}, {8'h00, 8'h00, 5'b00010});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
